// File: rtl/argmax_unit.sv
// Argmax over a snapshot of packed signed neuron results, scanned one element per enabled cycle.
// Handshake: start is a one-cycle request accepted only in IDLE; done pulses for one enabled cycle when index/max_value update.
module argmax_unit #(
  parameter int n                     = 8,
  parameter int number_of_input       = 10,
  parameter int clog2_number_of_input = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clk_en,
  input  logic                             start,
  input  logic [number_of_input*n-1:0]     values,
  output logic [clog2_number_of_input-1:0] index,
  output logic [n-1:0]                     max_value,
  output logic                             busy,
  output logic                             done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [clog2_number_of_input-1:0] LAST = clog2_number_of_input'(number_of_input - 1);

  state_t                             state;
  state_t                             state_next;
  logic [number_of_input*n-1:0]       snap;
  logic [clog2_number_of_input-1:0]   cnt;
  logic [clog2_number_of_input-1:0]   run_index;
  logic signed [n-1:0]                run_max;
  logic signed [n-1:0]                elem;
  logic                               greater;

  assign elem    = snap[cnt*n +: n];
  assign greater = elem > run_max;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (number_of_input == 1) ? DONE : SCAN;
      SCAN:    if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Running max/index stay internal; the visible result only moves on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snap      <= '0;
      cnt       <= '0;
      run_index <= '0;
      run_max   <= '0;
      index     <= '0;
      max_value <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (start) begin
            snap      <= values;
            run_max   <= values[n-1:0];
            run_index <= '0;
            cnt       <= (number_of_input == 1) ? '0 : clog2_number_of_input'(1);
            if (number_of_input == 1) begin
              index     <= '0;
              max_value <= values[n-1:0];
            end
          end
        end
        SCAN: begin
          if (greater) begin
            run_max   <= elem;
            run_index <= cnt;
          end
          if (cnt == LAST) begin
            index     <= greater ? cnt : run_index;
            max_value <= greater ? elem : run_max;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_unit.sv
// Directed bench for argmax_unit: a 4-input instance for the scan behaviour and a 1-input instance for the degenerate case.
module tb_argmax_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b1;
  logic        start4 = 1'b0;
  logic        start1 = 1'b0;
  logic [31:0] values4 = '0;
  logic [7:0]  values1 = '0;
  logic [1:0]  index4;
  logic [7:0]  max4;
  logic        busy4, done4;
  logic [0:0]  index1;
  logic [7:0]  max1;
  logic        busy1, done1;
  int checks = 0;
  int errors = 0;

  argmax_unit #(.n(8), .number_of_input(4), .clog2_number_of_input(2)) dut4 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start4), .values(values4),
    .index(index4), .max_value(max4), .busy(busy4), .done(done4)
  );

  argmax_unit #(.n(8), .number_of_input(1), .clog2_number_of_input(1)) dut1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start1), .values(values1),
    .index(index1), .max_value(max1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one scan and observes a fixed 14-cycle window; optional clk_en stall and mid-scan disturbance.
  task automatic scan4(input logic [31:0] vals, input int stall_at, input bit disturb,
                       output int lat, output int busy_cycles, output int done_cycles, output bit held);
    logic [1:0] prev_idx;
    logic [7:0] prev_max;
    prev_idx = index4; prev_max = max4;
    lat = 0; busy_cycles = 0; done_cycles = 0; held = 1'b1;
    values4 = vals; start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (busy4) busy_cycles++;
      if (done4) begin
        done_cycles++;
        if (lat == 0) lat = c;
      end else if (lat == 0 && (index4 !== prev_idx || max4 !== prev_max)) begin
        held = 1'b0;
      end
      if (disturb && c == 1) begin values4 = 32'h0000_0064; start4 = 1'b1; end
      if (disturb && c == 2) start4 = 1'b0;
      if (c == stall_at) clk_en = 1'b0;
      if (c == stall_at + 3) clk_en = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++; if (index4 !== 2'd0)  begin errors++; $display("FAIL reset_index4: got %0d expected 0", index4); end
    checks++; if (max4 !== 8'h00)   begin errors++; $display("FAIL reset_max4: got %h expected 00", max4); end
    checks++; if (busy4 !== 1'b0)   begin errors++; $display("FAIL reset_busy4: got %b expected 0", busy4); end
    checks++; if (done4 !== 1'b0)   begin errors++; $display("FAIL reset_done4: got %b expected 0", done4); end
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || max1 !== 8'h00 || index1 !== 1'b0)
      begin errors++; $display("FAIL reset_dut1: got busy=%b done=%b idx=%0d max=%h expected 0 0 0 00", busy1, done1, index1, max1); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat, bc, dc; bit held;
    scan4(32'h05_02_09_03, 0, 1'b0, lat, bc, dc, held);
    checks++; if (lat !== 4)        begin errors++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++; if (bc !== 4)         begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
    checks++; if (dc !== 1)         begin errors++; $display("FAIL basic_done_cycles: got %0d expected 1", dc); end
    checks++; if (index4 !== 2'd1)  begin errors++; $display("FAIL basic_index: got %0d expected 1", index4); end
    checks++; if (max4 !== 8'd9)    begin errors++; $display("FAIL basic_max: got %h expected 09", max4); end
    checks++; if (held !== 1'b1)    begin errors++; $display("FAIL basic_outputs_held: got %b expected 1", held); end
    checks++; if (busy4 !== 1'b0)   begin errors++; $display("FAIL basic_idle_after: got %b expected 0", busy4); end
  endtask

  task automatic test_ties();
    int lat, bc, dc; bit held;
    scan4(32'h07_01_07_07, 0, 1'b0, lat, bc, dc, held);
    checks++; if (index4 !== 2'd0)  begin errors++; $display("FAIL ties_index: got %0d expected 0", index4); end
    checks++; if (max4 !== 8'h07)   begin errors++; $display("FAIL ties_max: got %h expected 07", max4); end
    checks++; if (held !== 1'b1)    begin errors++; $display("FAIL ties_outputs_held: got %b expected 1", held); end
  endtask

  task automatic test_negative();
    int lat, bc, dc; bit held;
    scan4(32'hFD_F7_FE_FB, 0, 1'b0, lat, bc, dc, held);
    checks++; if (index4 !== 2'd1)  begin errors++; $display("FAIL neg_index: got %0d expected 1", index4); end
    checks++; if (max4 !== 8'hFE)   begin errors++; $display("FAIL neg_max: got %h expected FE", max4); end
    checks++; if (dc !== 1)         begin errors++; $display("FAIL neg_done_cycles: got %0d expected 1", dc); end
  endtask

  task automatic test_last_element();
    int lat, bc, dc; bit held;
    scan4(32'h7F_03_02_01, 0, 1'b0, lat, bc, dc, held);
    checks++; if (index4 !== 2'd3)  begin errors++; $display("FAIL last_index: got %0d expected 3", index4); end
    checks++; if (max4 !== 8'h7F)   begin errors++; $display("FAIL last_max: got %h expected 7F", max4); end
    checks++; if (lat !== 4)        begin errors++; $display("FAIL last_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_snapshot();
    int lat, bc, dc; bit held;
    scan4(32'h05_02_09_03, 0, 1'b1, lat, bc, dc, held);
    checks++; if (index4 !== 2'd1)  begin errors++; $display("FAIL snap_index: got %0d expected 1", index4); end
    checks++; if (max4 !== 8'd9)    begin errors++; $display("FAIL snap_max: got %h expected 09", max4); end
    checks++; if (dc !== 1)         begin errors++; $display("FAIL snap_done_cycles: got %0d expected 1", dc); end
    checks++; if (bc !== 4)         begin errors++; $display("FAIL snap_busy_cycles: got %0d expected 4", bc); end
    checks++; if (lat !== 4)        begin errors++; $display("FAIL snap_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_stall();
    int lat, bc, dc; bit held;
    scan4(32'hFD_F7_FE_FB, 1, 1'b0, lat, bc, dc, held);
    checks++; if (lat !== 7)        begin errors++; $display("FAIL stall_latency: got %0d expected 7", lat); end
    checks++; if (bc !== 7)         begin errors++; $display("FAIL stall_busy_cycles: got %0d expected 7", bc); end
    checks++; if (index4 !== 2'd1)  begin errors++; $display("FAIL stall_index: got %0d expected 1", index4); end
    checks++; if (max4 !== 8'hFE)   begin errors++; $display("FAIL stall_max: got %h expected FE", max4); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    values4 = 32'h7F_03_02_01; start4 = 1'b1;
    step();
    start4 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (done4) seen = 1'b1; else step();
    end
    checks++; if (seen !== 1'b1)    begin errors++; $display("FAIL b2b_first_done: got %b expected 1", seen); end
    values4 = 32'h07_01_07_07; start4 = 1'b1;
    step();
    start4 = 1'b0;
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0)
      begin errors++; $display("FAIL b2b_start_in_done_ignored: got busy=%b done=%b expected 0 0", busy4, done4); end
    checks++; if (index4 !== 2'd3)  begin errors++; $display("FAIL b2b_first_index: got %0d expected 3", index4); end
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    checks++; if (busy4 !== 1'b1)   begin errors++; $display("FAIL b2b_next_accepted: got %b expected 1", busy4); end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (done4) seen = 1'b1; else step();
    end
    checks++; if (seen !== 1'b1)    begin errors++; $display("FAIL b2b_second_done: got %b expected 1", seen); end
    checks++; if (index4 !== 2'd0 || max4 !== 8'h07)
      begin errors++; $display("FAIL b2b_second_result: got idx=%0d max=%h expected 0 07", index4, max4); end
    step();
  endtask

  task automatic test_reset_mid_scan();
    int dc, lat, bc; bit held;
    values4 = 32'h05_02_09_03; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (busy4 !== 1'b0)   begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy4); end
    checks++; if (index4 !== 2'd0)  begin errors++; $display("FAIL rstmid_index: got %0d expected 0", index4); end
    checks++; if (max4 !== 8'h00)   begin errors++; $display("FAIL rstmid_max: got %h expected 00", max4); end
    dc = 0;
    for (int c = 0; c < 6; c++) begin
      if (done4) dc++;
      step();
    end
    checks++; if (dc !== 0)         begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", dc); end
    rst = 1'b0; start4 = 1'b1;
    step();
    rst = 1'b1; start4 = 1'b0;
    checks++; if (busy4 !== 1'b0)   begin errors++; $display("FAIL rst_beats_start: got %b expected 0", busy4); end
    step();
    scan4(32'h7F_03_02_01, 0, 1'b0, lat, bc, dc, held);
    checks++; if (lat !== 4 || index4 !== 2'd3 || max4 !== 8'h7F)
      begin errors++; $display("FAIL rstmid_rescan: got lat=%0d idx=%0d max=%h expected 4 3 7F", lat, index4, max4); end
  endtask

  task automatic test_single_input();
    values1 = 8'hFC; start1 = 1'b1;
    step();
    start1 = 1'b0;
    checks++; if (done1 !== 1'b1)   begin errors++; $display("FAIL n1_done: got %b expected 1", done1); end
    checks++; if (busy1 !== 1'b1)   begin errors++; $display("FAIL n1_busy: got %b expected 1", busy1); end
    checks++; if (index1 !== 1'b0)  begin errors++; $display("FAIL n1_index: got %0d expected 0", index1); end
    checks++; if (max1 !== 8'hFC)   begin errors++; $display("FAIL n1_max: got %h expected FC", max1); end
    step();
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0)
      begin errors++; $display("FAIL n1_return_idle: got done=%b busy=%b expected 0 0", done1, busy1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_negative();
    test_last_element();
    test_snapshot();
    test_stall();
    test_back_to_back();
    test_reset_mid_scan();
    test_single_input();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
